// File: rtl/aes_pkg.sv
// Shared AES key-schedule types: round count, sequencer states and round-key type.
package aes_pkg;
  localparam int AES256_NROUNDS = 15;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    GAP,
    READY,
    ERROR
  } ks_state_t;

  typedef logic [127:0] rkey_t;
endpackage

// File: rtl/aes_rkey_buffer.sv
// Round-key register file: one synchronous write port, one registered read port.
module aes_rkey_buffer
  import aes_pkg::*;
#(
  parameter int NROUNDS = AES256_NROUNDS
) (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic       i_wr_en,
  input  logic [3:0] i_wr_idx,
  input  rkey_t      i_wr_data,
  input  logic       i_rd_en,
  input  logic [3:0] i_rd_idx,
  output logic       o_rd_valid,
  output rkey_t      o_rd_data
);

  rkey_t r_mem [NROUNDS];
  logic  r_rd_valid;
  rkey_t r_rd_data;

  // Storage carries no reset; contents only become visible once READY is reached.
  always_ff @(posedge clk_i) begin
    if (i_wr_en && (int'(i_wr_idx) < NROUNDS)) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= i_rd_en;
      if (i_rd_en && (int'(i_rd_idx) < NROUNDS)) begin
        r_rd_data <= r_mem[i_rd_idx];
      end else begin
        r_rd_data <= '0;
      end
    end
  end

  assign o_rd_valid = r_rd_valid;
  assign o_rd_data  = r_rd_data;

endmodule

// File: rtl/aes_key_sequencer.sv
// Steps the AES-256 key schedule through every round, buffers the round keys and
// serves indexed reads once the whole schedule is captured.
module aes_key_sequencer
  import aes_pkg::*;
#(
  parameter int NROUNDS = AES256_NROUNDS,
  parameter int TIMEOUT = 16
) (
  input  logic         clk_i,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [255:0] key_i,
  output logic [255:0] ks_key_o,
  output logic         ks_en_o,
  output logic         ks_hold_o,
  output logic [3:0]   ks_round_o,
  input  logic         ks_done_i,
  input  rkey_t        ks_rkey_i,
  output logic         busy_o,
  output logic         ready_o,
  output logic         err_o,
  input  logic         rk_req_i,
  input  logic [3:0]   rk_idx_i,
  output logic         rk_valid_o,
  output rkey_t        rk_o
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  ks_state_t        r_state;
  ks_state_t        w_next;
  logic [3:0]       r_round;
  logic [WD_W-1:0]  r_wdog;
  logic [255:0]     r_key;
  logic             r_active;
  logic             r_busy;
  logic             r_ready;
  logic             r_err;

  logic w_accept;
  logic w_capture;
  logic w_last;
  logic w_rd_en;

  assign w_accept  = start_i && ((r_state == IDLE) || (r_state == READY) || (r_state == ERROR));
  assign w_capture = (r_state == RUN) && ks_done_i;
  assign w_last    = (r_round == 4'(NROUNDS - 1));
  assign w_rd_en   = rk_req_i && (r_state == READY);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, READY, ERROR: begin
        if (start_i) w_next = RUN;
      end
      RUN: begin
        if (ks_done_i) begin
          w_next = w_last ? READY : GAP;
        end else if (r_wdog == WD_W'(TIMEOUT - 1)) begin
          w_next = ERROR;
        end
      end
      // The key schedule returns from LOAD to IDLE here; its strobe is not trusted.
      GAP:     w_next = RUN;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_round  <= '0;
      r_wdog   <= '0;
      r_key    <= '0;
      r_active <= 1'b0;
      r_busy   <= 1'b0;
      r_ready  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_key   <= key_i;
        r_round <= '0;
        r_wdog  <= '0;
      end else if (r_state == RUN) begin
        if (ks_done_i) begin
          if (!w_last) r_round <= r_round + 4'd1;
          r_wdog <= '0;
        end else begin
          r_wdog <= r_wdog + WD_W'(1);
        end
      end
      // Status flags are decoded from the next state so they line up with it.
      r_active <= (w_next == RUN) || (w_next == GAP);
      r_busy   <= (w_next == RUN) || (w_next == GAP);
      r_ready  <= (w_next == READY);
      r_err    <= (w_next == ERROR);
    end
  end

  aes_rkey_buffer #(
    .NROUNDS (NROUNDS)
  ) u_buf (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .i_wr_en    (w_capture),
    .i_wr_idx   (r_round),
    .i_wr_data  (ks_rkey_i),
    .i_rd_en    (w_rd_en),
    .i_rd_idx   (rk_idx_i),
    .o_rd_valid (rk_valid_o),
    .o_rd_data  (rk_o)
  );

  assign ks_key_o   = r_key;
  assign ks_en_o    = r_active;
  assign ks_hold_o  = r_active;
  assign ks_round_o = r_round;
  assign busy_o     = r_busy;
  assign ready_o    = r_ready;
  assign err_o      = r_err;

endmodule

// File: tb/tb_aes_key_sequencer.sv
// Bench for aes_key_sequencer with a behavioural AES-256 key schedule (latency 3).
module tb_aes_key_sequencer;
  import aes_pkg::*;

  localparam int NR = 15;
  localparam int L  = 3;
  localparam logic [255:0] KEY_A = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY_B = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] JUNK  = 128'hdeadbeef_cafef00d_0badc0de_5a5a5a5a;

  logic         clk_i = 1'b0;
  logic         rst_n = 1'b1;
  logic         start_i = 1'b0;
  logic [255:0] key_i = '0;
  logic [255:0] ks_key_o;
  logic         ks_en_o, ks_hold_o;
  logic [3:0]   ks_round_o;
  logic         ks_done_i = 1'b0;
  rkey_t        ks_rkey_i = '0;
  logic         busy_o, ready_o, err_o;
  logic         rk_req_i = 1'b0;
  logic [3:0]   rk_idx_i = '0;
  logic         rk_valid_o;
  rkey_t        rk_o;

  int total = 0;
  int bad   = 0;

  logic [7:0]        sbox [256];
  logic [NR*128-1:0] exp_a, exp_b;
  int                stall_round = -1;
  bit                force_done = 1'b0;
  int                ks_cnt = 0;

  aes_key_sequencer #(.NROUNDS(15), .TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .start_i(start_i), .key_i(key_i),
    .ks_key_o(ks_key_o), .ks_en_o(ks_en_o), .ks_hold_o(ks_hold_o),
    .ks_round_o(ks_round_o), .ks_done_i(ks_done_i), .ks_rkey_i(ks_rkey_i),
    .busy_o(busy_o), .ready_o(ready_o), .err_o(err_o),
    .rk_req_i(rk_req_i), .rk_idx_i(rk_idx_i), .rk_valid_o(rk_valid_o), .rk_o(rk_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic logic [NR*128-1:0] expand(input logic [255:0] k);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    logic [NR*128-1:0] res;
    for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < NR; r++) res[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return res;
  endfunction

  // Behavioural key schedule: done on the L-th enabled cycle, then one idle cycle.
  always @(posedge clk_i) begin
    logic nat;
    #1;
    nat = 1'b0;
    if (!ks_en_o) begin
      ks_cnt = 0;
    end else begin
      ks_cnt++;
      if (ks_cnt == L && int'(ks_round_o) != stall_round) begin
        nat    = 1'b1;
        ks_cnt = -1;
      end
    end
    ks_done_i = nat | force_done;
    if (force_done)          ks_rkey_i = JUNK;
    else if (ks_key_o == KEY_B) ks_rkey_i = exp_b[int'(ks_round_o)*128 +: 128];
    else                     ks_rkey_i = exp_a[int'(ks_round_o)*128 +: 128];
  end

  task automatic start_exp(input logic [255:0] k);
    start_i = 1'b1;
    key_i   = k;
    @(negedge clk_i);
    start_i = 1'b0;
    key_i   = ~k;
  endtask

  task automatic wait_ready(input int c0, output int cyc);
    cyc = c0;
    while (!ready_o && !err_o && cyc < 200) begin
      @(negedge clk_i);
      cyc++;
    end
  endtask

  task automatic do_read(input logic [3:0] idx, output logic v, output rkey_t d);
    rk_req_i = 1'b1;
    rk_idx_i = idx;
    @(negedge clk_i);
    v = rk_valid_o;
    d = rk_o;
    rk_req_i = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk_i);
    total++;
    if ({busy_o, ready_o, err_o, ks_en_o, ks_hold_o, rk_valid_o} !== 6'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 000000",
                      {busy_o, ready_o, err_o, ks_en_o, ks_hold_o, rk_valid_o});
    end
    total++;
    if (ks_round_o !== 4'd0 || ks_key_o !== 256'd0 || rk_o !== 128'd0) begin
      bad++; $display("FAIL reset_data: round=%0d key=%h rk=%h want zeros", ks_round_o, ks_key_o, rk_o);
    end
    rst_n = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_full_expansion();
    int cyc;
    logic v;
    rkey_t d;
    start_exp(KEY_A);
    total++;
    if ({busy_o, ks_en_o, ks_hold_o, ready_o} !== 4'b1110 || ks_round_o !== 4'd0) begin
      bad++; $display("FAIL run_entry: flags=%b round=%0d want 1110 round 0",
                      {busy_o, ks_en_o, ks_hold_o, ready_o}, ks_round_o);
    end
    total++;
    if (ks_key_o !== KEY_A) begin
      bad++; $display("FAIL key_latch: got %h want %h", ks_key_o, KEY_A);
    end
    wait_ready(1, cyc);
    total++;
    if (cyc != 60) begin bad++; $display("FAIL ready_cycle: got %0d want 60", cyc); end
    total++;
    if ({ks_en_o, ks_hold_o, busy_o, err_o} !== 4'b0000) begin
      bad++; $display("FAIL ready_flags: got %b want 0000", {ks_en_o, ks_hold_o, busy_o, err_o});
    end
    do_read(4'd0, v, d);
    total++;
    if (v !== 1'b1 || d !== 128'h000102030405060708090a0b0c0d0e0f) begin
      bad++; $display("FAIL read_idx0: valid=%b got %h want 000102030405060708090a0b0c0d0e0f", v, d);
    end
    do_read(4'd14, v, d);
    total++;
    if (v !== 1'b1 || d !== 128'h24fc79ccbf0979e9371ac23c6d68de36) begin
      bad++; $display("FAIL read_idx14: valid=%b got %h want 24fc79ccbf0979e9371ac23c6d68de36", v, d);
    end
    for (int i = 0; i < NR; i++) begin
      do_read(4'(i), v, d);
      total++;
      if (v !== 1'b1 || d !== exp_a[i*128 +: 128]) begin
        bad++; $display("FAIL read_all[%0d]: valid=%b got %h want %h", i, v, d, exp_a[i*128 +: 128]);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic v;
    rkey_t d;
    do_read(4'd15, v, d);
    total++;
    if (v !== 1'b1 || d !== 128'd0) begin
      bad++; $display("FAIL read_idx15: valid=%b got %h want valid 1 data 0", v, d);
    end
  endtask

  task automatic test_watchdog();
    int cyc;
    logic v;
    rkey_t d;
    stall_round = 5;
    start_exp(KEY_A);
    cyc = 1;
    while (!err_o && cyc < 100) begin
      @(negedge clk_i);
      cyc++;
    end
    total++;
    if (cyc != 37) begin bad++; $display("FAIL wdog_cycle: got %0d want 37", cyc); end
    total++;
    if ({err_o, ks_en_o, ks_hold_o, busy_o, ready_o} !== 5'b10000) begin
      bad++; $display("FAIL wdog_flags: got %b want 10000", {err_o, ks_en_o, ks_hold_o, busy_o, ready_o});
    end
    do_read(4'd0, v, d);
    total++;
    if (v !== 1'b0 || d !== 128'd0) begin
      bad++; $display("FAIL read_in_error: valid=%b got %h want 0/0", v, d);
    end
    stall_round = -1;
    start_exp(KEY_A);
    total++;
    if (err_o !== 1'b0 || busy_o !== 1'b1) begin
      bad++; $display("FAIL err_clear: err=%b busy=%b want 0/1", err_o, busy_o);
    end
    wait_ready(1, cyc);
    total++;
    if (cyc != 60) begin bad++; $display("FAIL retry_ready_cycle: got %0d want 60", cyc); end
    do_read(4'd5, v, d);
    total++;
    if (v !== 1'b1 || d !== exp_a[5*128 +: 128]) begin
      bad++; $display("FAIL retry_idx5: got %h want %h", d, exp_a[5*128 +: 128]);
    end
  endtask

  task automatic test_spurious_done();
    int cyc;
    logic v;
    rkey_t d;
    force_done = 1'b1;
    @(negedge clk_i);
    force_done = 1'b0;
    @(negedge clk_i);
    total++;
    if (ready_o !== 1'b1 || busy_o !== 1'b0) begin
      bad++; $display("FAIL ready_spurious_state: ready=%b busy=%b want 1/0", ready_o, busy_o);
    end
    do_read(4'd3, v, d);
    total++;
    if (d !== exp_a[3*128 +: 128]) begin
      bad++; $display("FAIL ready_spurious_idx3: got %h want %h", d, exp_a[3*128 +: 128]);
    end
    do_read(4'd14, v, d);
    total++;
    if (d !== exp_a[14*128 +: 128]) begin
      bad++; $display("FAIL ready_spurious_idx14: got %h want %h", d, exp_a[14*128 +: 128]);
    end
    start_exp(KEY_A);
    repeat (10) @(negedge clk_i);
    force_done = 1'b1;
    @(negedge clk_i);
    force_done = 1'b0;
    total++;
    if (ks_round_o !== 4'd3 || busy_o !== 1'b1) begin
      bad++; $display("FAIL gap_round: round=%0d busy=%b want 3/1", ks_round_o, busy_o);
    end
    wait_ready(12, cyc);
    total++;
    if (cyc != 60) begin bad++; $display("FAIL gap_spurious_ready_cycle: got %0d want 60", cyc); end
    do_read(4'd3, v, d);
    total++;
    if (d !== exp_a[3*128 +: 128]) begin
      bad++; $display("FAIL gap_spurious_idx3: got %h want %h", d, exp_a[3*128 +: 128]);
    end
  endtask

  task automatic test_start_in_run();
    int cyc;
    logic v;
    rkey_t d;
    start_exp(KEY_A);
    repeat (5) @(negedge clk_i);
    start_i = 1'b1;
    key_i   = KEY_B;
    @(negedge clk_i);
    start_i = 1'b0;
    total++;
    if (ks_key_o !== KEY_A || ks_round_o !== 4'd1) begin
      bad++; $display("FAIL start_in_run: key=%h round=%0d want KEY_A round 1", ks_key_o, ks_round_o);
    end
    wait_ready(7, cyc);
    total++;
    if (cyc != 60) begin bad++; $display("FAIL start_in_run_ready: got %0d want 60", cyc); end
    do_read(4'd2, v, d);
    total++;
    if (d !== exp_a[2*128 +: 128]) begin
      bad++; $display("FAIL start_in_run_idx2: got %h want %h", d, exp_a[2*128 +: 128]);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic v;
    rkey_t d;
    start_i  = 1'b1;
    key_i    = KEY_B;
    rk_req_i = 1'b1;
    rk_idx_i = 4'd2;
    @(negedge clk_i);
    start_i  = 1'b0;
    rk_req_i = 1'b0;
    total++;
    if (rk_valid_o !== 1'b1 || rk_o !== exp_a[2*128 +: 128]) begin
      bad++; $display("FAIL b2b_read: valid=%b got %h want %h", rk_valid_o, rk_o, exp_a[2*128 +: 128]);
    end
    total++;
    if (ready_o !== 1'b0 || busy_o !== 1'b1 || ks_key_o !== KEY_B) begin
      bad++; $display("FAIL b2b_start: ready=%b busy=%b key=%h", ready_o, busy_o, ks_key_o);
    end
    wait_ready(1, cyc);
    total++;
    if (cyc != 60) begin bad++; $display("FAIL b2b_ready_cycle: got %0d want 60", cyc); end
    do_read(4'd2, v, d);
    total++;
    if (d !== exp_b[2*128 +: 128]) begin
      bad++; $display("FAIL b2b_new_idx2: got %h want %h", d, exp_b[2*128 +: 128]);
    end
    do_read(4'd14, v, d);
    total++;
    if (d !== exp_b[14*128 +: 128]) begin
      bad++; $display("FAIL b2b_new_idx14: got %h want %h", d, exp_b[14*128 +: 128]);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit seen_ready;
    logic v;
    rkey_t d;
    start_exp(KEY_A);
    cyc = 1;
    while (ks_round_o != 4'd7 && cyc < 100) begin
      @(negedge clk_i);
      cyc++;
    end
    total++;
    if (ks_round_o !== 4'd7) begin bad++; $display("FAIL mid_round: got %0d want 7", ks_round_o); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({ks_en_o, ks_hold_o, busy_o, ready_o, err_o} !== 5'b0 || ks_round_o !== 4'd0 || ks_key_o !== 256'd0) begin
      bad++; $display("FAIL mid_reset_async: flags=%b round=%0d key=%h want zeros",
                      {ks_en_o, ks_hold_o, busy_o, ready_o, err_o}, ks_round_o, ks_key_o);
    end
    @(negedge clk_i);
    rst_n = 1'b1;
    seen_ready = 1'b0;
    repeat (70) begin
      @(negedge clk_i);
      if (ready_o) seen_ready = 1'b1;
    end
    total++;
    if (seen_ready) begin bad++; $display("FAIL mid_reset_ready: got ready 1 want 0"); end
    do_read(4'd0, v, d);
    total++;
    if (v !== 1'b0 || d !== 128'd0) begin
      bad++; $display("FAIL mid_reset_read: valid=%b got %h want 0/0", v, d);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) sbox[i] = sbox_calc(8'(i));
    exp_a = expand(KEY_A);
    exp_b = expand(KEY_B);
    test_reset();
    test_full_expansion();
    test_out_of_range();
    test_watchdog();
    test_spurious_done();
    test_start_in_run();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
